// File: rtl/rooth_dmem_arb_if.sv
// Bus bundle between the two data-RAM requesters, the arbiter and the RAM.
// slave = arbiter view; master = requesters plus RAM view.
interface rooth_dmem_arb_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [3:0]            m0_wstrb;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [3:0]            m1_wstrb;
    logic                  m1_lock;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  ram_ce;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [3:0]            ram_wstrb;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
        input  ram_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_ce, ram_we, ram_addr, ram_wdata, ram_wstrb
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
        output ram_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_ce, ram_we, ram_addr, ram_wdata, ram_wstrb
    );
endinterface

// File: rtl/rooth_dmem_arb.sv
// Two-port arbiter in front of the single-port data RAM, with port-1 bus lock.
// Define ROOTH_DMEM_ARB_RR_EN for round-robin conflicts; default is port 0 fixed priority.

// Per-port read-return stage: data is forced to zero unless this port owns the return.
module rooth_dmem_arb_ret #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  hit,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);
    assign rvalid = hit;
    assign rdata  = hit ? ram_rdata : '0;
endmodule

module rooth_dmem_arb #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    rooth_dmem_arb_if.slave bus
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [3:0]            wstrb;
    } req_t;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                               state_q, state_d;
    req_t   [NUM_PORTS-1:0]               port_cmd;
    req_t                                 ram_cmd;
    logic   [NUM_PORTS-1:0]               port_req;
    logic   [NUM_PORTS-1:0]               gnt;
    logic   [NUM_PORTS-1:0]               rvalid;
    logic   [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic                                 prefer_m1;
    logic                                 rd_pend_q;
    logic                                 rd_owner_q;
    logic                                 rd_issue;

    assign port_req    = {bus.m1_req, bus.m0_req};
    assign port_cmd[0] = {bus.m0_we, bus.m0_addr, bus.m0_wdata, bus.m0_wstrb};
    assign port_cmd[1] = {bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.m1_wstrb};

`ifdef ROOTH_DMEM_ARB_RR_EN
    logic rr_ptr_q;

    // Pointer names the port preferred on the next conflict: the one not granted last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_ptr_q <= 1'b0;
        else if (|gnt) rr_ptr_q <= gnt[0];
    end

    assign prefer_m1 = rr_ptr_q;
`else
    assign prefer_m1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grants are held low while reset is asserted so nothing reaches the RAM.
    always_comb begin
        state_d = state_q;
        gnt     = '0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (&port_req) gnt = prefer_m1 ? 2'b10 : 2'b01;
                    else           gnt = port_req;
                    if (gnt[1] && bus.m1_lock) state_d = LOCK;
                end
                LOCK: begin
                    gnt[1] = port_req[1];
                    if (!bus.m1_lock) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_cmd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) ram_cmd = port_cmd[p];
        end
    end

    assign bus.ram_ce = |gnt;
    assign {bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wstrb} = ram_cmd;
    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];

    // Read return is tracked independently of the lock, so an issued read always returns.
    assign rd_issue = bus.ram_ce && !ram_cmd.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_issue;
            if (rd_issue) rd_owner_q <= gnt[1];
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        rooth_dmem_arb_ret #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ret (
            .hit       (rd_pend_q && (int'(rd_owner_q) == g)),
            .ram_rdata (bus.ram_rdata),
            .rvalid    (rvalid[g]),
            .rdata     (rdata[g])
        );
    end

    assign bus.m0_rvalid = rvalid[0];
    assign bus.m0_rdata  = rdata[0];
    assign bus.m1_rvalid = rvalid[1];
    assign bus.m1_rdata  = rdata[1];
endmodule

// File: tb/tb_rooth_dmem_arb.sv
// Randomized scoreboard bench for rooth_dmem_arb with a transaction-level reference model
// and a behavioural RAM behind the arbiter.
module tb_rooth_dmem_arb;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int WORDS = 32;
    localparam int RW    = 2 + AW + DW + 4;
    localparam int OW    = 4 + 2 * DW + RW;

    typedef struct {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
    } cmd_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    cmd_t          cmd [2];
    logic          lock1;
    logic [DW-1:0] ram    [WORDS];
    logic [DW-1:0] shadow [WORDS];
    exp_t          sbq [$];
    bit            locked;
    int            last_gnt;

    rooth_dmem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rooth_dmem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wstrb[b]) ram[bus.ram_addr[4:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end else begin
                bus.ram_rdata <= ram[bus.ram_addr[4:0]];
            end
        end
    end

    logic [1:0]         rv;
    logic [1:0][DW-1:0] rd;
    logic [RW-1:0]      ram_bus;
    logic [OW-1:0]      all_out;
    assign rv      = {bus.m1_rvalid, bus.m0_rvalid};
    assign rd      = {bus.m1_rdata, bus.m0_rdata};
    assign ram_bus = {bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wstrb};
    assign all_out = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                      bus.m0_rdata, bus.m1_rdata, ram_bus};

    function automatic cmd_t idle_cmd();
        cmd_t c;
        c.req = 1'b0; c.we = 1'b0; c.addr = '0; c.wdata = '0; c.wstrb = '0;
        return c;
    endfunction

    function automatic cmd_t mk_cmd(logic we, int addr, logic [DW-1:0] wdata, logic [3:0] wstrb);
        cmd_t c;
        c.req = 1'b1; c.we = we; c.addr = AW'(addr); c.wdata = wdata; c.wstrb = wstrb;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.req   = ($urandom_range(0, 3) != 0);
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = AW'($urandom_range(0, WORDS - 1));
        c.wdata = $urandom;
        c.wstrb = 4'($urandom_range(0, 15));
        return c;
    endfunction

    // Winner from the arbitration rules; -1 means the RAM stays idle.
    function automatic int predict();
        if (locked) return cmd[1].req ? 1 : -1;
        if (cmd[0].req && cmd[1].req) begin
`ifdef ROOTH_DMEM_ARB_RR_EN
            return (last_gnt == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (cmd[0].req) return 0;
        if (cmd[1].req) return 1;
        return -1;
    endfunction

    task automatic drive();
        bus.m0_req   = cmd[0].req;   bus.m0_we    = cmd[0].we;
        bus.m0_addr  = cmd[0].addr;  bus.m0_wdata = cmd[0].wdata;
        bus.m0_wstrb = cmd[0].wstrb;
        bus.m1_req   = cmd[1].req;   bus.m1_we    = cmd[1].we;
        bus.m1_addr  = cmd[1].addr;  bus.m1_wdata = cmd[1].wdata;
        bus.m1_wstrb = cmd[1].wstrb; bus.m1_lock  = lock1;
    endtask

    task automatic step(output int win);
        logic [1:0]    exp_gnt;
        logic [RW-1:0] exp_ram;
        exp_t          e;
        drive();
        @(negedge clk);
        win     = predict();
        exp_gnt = (win < 0) ? 2'b00 : 2'(1 << win);
        exp_ram = '0;
        if (win >= 0)
            exp_ram = {1'b1, cmd[win].we, cmd[win].addr, cmd[win].wdata, cmd[win].wstrb};
        vectors++;
        if ({bus.m1_gnt, bus.m0_gnt} !== exp_gnt) begin
            miscompares++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, {bus.m1_gnt, bus.m0_gnt}, exp_gnt);
        end
        vectors++;
        if (ram_bus !== exp_ram) begin
            miscompares++;
            $display("FAIL ram_cmd cyc=%0d got=%h exp=%h", cyc, ram_bus, exp_ram);
        end
        if (win >= 0) begin
            if (cmd[win].we) begin
                for (int b = 0; b < 4; b++)
                    if (cmd[win].wstrb[b]) shadow[cmd[win].addr[4:0]][8*b +: 8] = cmd[win].wdata[8*b +: 8];
            end else begin
                e.port = win;
                e.data = shadow[cmd[win].addr[4:0]];
                e.due  = cyc + 1;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        if (locked) begin
            if (!lock1) locked = 1'b0;
        end else if (win == 1 && lock1) begin
            locked = 1'b1;
        end
        if (win >= 0) last_gnt = win;
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL %s outputs_in_reset got=%h exp=0", tag, all_out);
        end
    endtask

    // Monitor: every read return must match the oldest outstanding read, exactly one cycle late.
    initial begin
        exp_t e;
        int   p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int q = 0; q < 2; q++) begin
                    vectors++;
                    if (!rv[q] && rd[q] !== '0) begin
                        miscompares++;
                        $display("FAIL rdata_idle port=%0d cyc=%0d got=%h exp=0", q, cyc, rd[q]);
                    end
                end
                if (rv == 2'b11) begin
                    vectors++; miscompares++;
                    $display("FAIL rvalid_both cyc=%0d got=11 exp=onehot", cyc);
                    if (sbq.size() != 0) void'(sbq.pop_front());
                end else if (rv != 2'b00) begin
                    p = rv[1] ? 1 : 0;
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL rvalid_unexpected port=%0d cyc=%0d got=1 exp=0", p, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.port != p || e.due != cyc || rd[p] !== e.data) begin
                            miscompares++;
                            $display("FAIL rdata port=%0d cyc=%0d got=%h exp_port=%0d exp_cyc=%0d exp=%h",
                                     p, cyc, rd[p], e.port, e.due, e.data);
                        end
                    end
                end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                    vectors++; miscompares++;
                    $display("FAIL rvalid_missing port=%0d cyc=%0d got=0 exp=1", sbq[0].port, cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int w;
        locked   = 1'b0;
        last_gnt = 1;
        lock1    = 1'b0;
        cmd[0]   = mk_cmd(1'b0, 3, '0, 4'h0);
        cmd[1]   = idle_cmd();
        bus.ram_rdata = '0;
        drive();
        #2 check_reset_outputs("por");
        @(posedge clk); @(negedge clk);
        check_reset_outputs("por_hold");
        cmd[0] = idle_cmd();
        drive();
        @(posedge clk); #1 rst_n = 1'b1;

        // Port 0 write then read-back of 0xDEADBEEF.
        cmd[0] = mk_cmd(1'b1, 'h010, 32'hDEADBEEF, 4'hF); step(w);
        cmd[0] = mk_cmd(1'b0, 'h010, '0, 4'h0);           step(w);
        cmd[0] = idle_cmd();                              step(w);

        // Loader preloads the rest of the window through port 1.
        for (int a = 0; a < WORDS; a++) begin
            if (a != 'h010) begin
                cmd[1] = mk_cmd(1'b1, a, $urandom, 4'hF);
                step(w);
            end
        end
        cmd[1] = idle_cmd();

        // Both ports read every cycle.
        for (int i = 0; i < 4; i++) begin
            cmd[0] = mk_cmd(1'b0, 'h0, '0, 4'h0);
            cmd[1] = mk_cmd(1'b0, 'h4, '0, 4'h0);
            step(w);
        end
        cmd[0] = idle_cmd(); cmd[1] = idle_cmd(); step(w);

        // Port-1 locked burst with port 0 waiting, including an idle locked cycle.
        lock1 = 1'b1; cmd[1] = mk_cmd(1'b1, 1, $urandom, 4'hF); step(w);
        cmd[0] = mk_cmd(1'b0, 7, '0, 4'h0);
        cmd[1] = mk_cmd(1'b1, 2, $urandom, 4'hF);               step(w);
        cmd[1] = idle_cmd();                                    step(w);
        cmd[1] = mk_cmd(1'b1, 3, $urandom, 4'h5);               step(w);
        lock1 = 1'b0; cmd[1] = mk_cmd(1'b1, 4, $urandom, 4'hF); step(w);
        cmd[1] = idle_cmd();                                    step(w);
        cmd[0] = idle_cmd();                                    step(w);

        // Alternating reads from the two ports.
        for (int i = 0; i < 6; i++) begin
            cmd[i % 2]       = mk_cmd(1'b0, $urandom_range(0, WORDS - 1), '0, 4'h0);
            cmd[1 - (i % 2)] = idle_cmd();
            step(w);
        end
        cmd[0] = idle_cmd(); cmd[1] = idle_cmd(); step(w);

        // Reset lands between a read grant and its return: the return is dropped.
        cmd[0] = mk_cmd(1'b0, 9, '0, 4'h0); step(w);
        rst_n = 1'b0;
        sbq.delete();
        #1 check_reset_outputs("mid_read");
        @(negedge clk);
        check_reset_outputs("mid_read_hold");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        locked   = 1'b0;
        last_gnt = 1;
        cmd[0]   = idle_cmd();
        for (int i = 0; i < 3; i++) step(w);

        // Randomized traffic with occasional port-1 locks.
        w = -1;
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < 2; p++)
                if (!cmd[p].req || w == p) cmd[p] = rand_cmd();
            lock1 = locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(w);
        end
        cmd[0] = idle_cmd(); cmd[1] = idle_cmd(); lock1 = 1'b0;
        for (int i = 0; i < 4; i++) step(w);

        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL read_drain got=%0d outstanding exp=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
